// File: rtl/slot_pkg.sv
// Shared types and defaults for the slot reel controller.
// Round states, default constants and a saturating adder.
package slot_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SPIN,
        EVAL
    } state_e;

    localparam logic [15:0] DEF_SEED     = 16'hACE1;
    localparam logic [15:0] DEF_TAPS     = 16'hB400;
    localparam int          DEF_WIN_PTS  = 10;
    localparam int          DEF_PAIR_PTS = 1;

    function automatic logic [31:0] sat_add(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [31:0] max
    );
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, max}) ? max : sum[31:0];
    endfunction

endpackage

// File: rtl/slot_reel_controller_lfsr.sv
// Free-running Galois LFSR feeding the reel symbols.
// A zero seed would lock up, so it is replaced by 1.
module lfsr_galois #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(16'hACE1),
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(16'hB400)
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] lfsr
);

    localparam logic [WIDTH-1:0] SEED_EFF =
        (SEED == '0) ? WIDTH'(1) : SEED;

    logic [WIDTH-1:0] lfsr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= SEED_EFF;
        end else if (lfsr_q[0]) begin
            lfsr_q <= (lfsr_q >> 1) ^ TAPS;
        end else begin
            lfsr_q <= lfsr_q >> 1;
        end
    end

    assign lfsr = lfsr_q;

endmodule

// File: rtl/slot_reel_controller.sv
// N-reel slot controller: spin, per-reel stop or timeout,
// then evaluate win/pair and accumulate a saturating score.
module slot_reel_controller
    import slot_pkg::*;
#(
    parameter int                NUM_REELS = 3,
    parameter int                SYM_W     = 2,
    parameter int                LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_W'(DEF_SEED),
    parameter logic [LFSR_W-1:0] LFSR_TAPS = LFSR_W'(DEF_TAPS),
    parameter int                MAX_SPIN  = 15,
    parameter int                SCORE_W   = 8,
    parameter int                WIN_PTS   = DEF_WIN_PTS,
    parameter int                PAIR_PTS  = DEF_PAIR_PTS
) (
    input  logic                       clk_1Hz,
    input  logic                       rst,
    input  logic                       start,
    input  logic [NUM_REELS-1:0]       stop,
    output logic [NUM_REELS*SYM_W-1:0] reels,
    output logic [NUM_REELS-1:0]       spinning,
    output logic                       busy,
    output logic                       round_done,
    output logic                       win,
    output logic                       pair,
    output logic [SCORE_W-1:0]         score
);

    localparam int RW = NUM_REELS * SYM_W;
    localparam int CW = $clog2(MAX_SPIN + 1);
    localparam logic [31:0] SCORE_MAX = 32'((64'd1 << SCORE_W) - 1);

    state_e               state_q;
    logic [RW-1:0]        reels_q, reels_d;
    logic [NUM_REELS-1:0] spin_q, spin_d;
    logic [CW-1:0]        cnt_q;
    logic                 done_q, win_q, pair_q;
    logic [SCORE_W-1:0]   score_q;

    logic [LFSR_W-1:0]    lfsr;
    logic                 lfsr_unused;
    logic                 all_eq, any_eq, timeout;
    logic [31:0]          pts;

    lfsr_galois #(
        .WIDTH (LFSR_W),
        .SEED  (LFSR_SEED),
        .TAPS  (LFSR_TAPS)
    ) u_lfsr (
        .clk  (clk_1Hz),
        .rst  (rst),
        .lfsr (lfsr)
    );

    assign lfsr_unused = ^lfsr;

    // All-equal holds only if every pair matches.
    always_comb begin
        all_eq = 1'b1;
        any_eq = 1'b0;
        for (int i = 0; i < NUM_REELS; i++) begin
            for (int j = i + 1; j < NUM_REELS; j++) begin
                if (reels_q[i*SYM_W +: SYM_W] ==
                    reels_q[j*SYM_W +: SYM_W]) begin
                    any_eq = 1'b1;
                end else begin
                    all_eq = 1'b0;
                end
            end
        end
    end

    assign pts = all_eq ? 32'(WIN_PTS) :
                 any_eq ? 32'(PAIR_PTS) : 32'd0;

    assign timeout = (cnt_q == CW'(MAX_SPIN - 1));

    // A stopping reel is held, not loaded, on its stop edge.
    always_comb begin
        spin_d  = spin_q;
        reels_d = reels_q;
        for (int i = 0; i < NUM_REELS; i++) begin
            if (spin_q[i]) begin
                if (stop[i] || timeout) begin
                    spin_d[i] = 1'b0;
                end else begin
                    reels_d[i*SYM_W +: SYM_W] =
                        lfsr[i*SYM_W +: SYM_W];
                end
            end
        end
    end

    always_ff @(posedge clk_1Hz or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            reels_q <= '0;
            spin_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            win_q   <= 1'b0;
            pair_q  <= 1'b0;
            score_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= SPIN;
                        spin_q  <= '1;
                        cnt_q   <= '0;
                    end
                end
                SPIN: begin
                    cnt_q   <= cnt_q + CW'(1);
                    spin_q  <= spin_d;
                    reels_q <= reels_d;
                    if (spin_d == '0) begin
                        state_q <= EVAL;
                    end
                end
                EVAL: begin
                    win_q   <= all_eq;
                    pair_q  <= !all_eq && any_eq;
                    score_q <= SCORE_W'(sat_add(
                        32'(score_q), pts, SCORE_MAX));
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign reels      = reels_q;
    assign spinning   = spin_q;
    assign busy       = (state_q != IDLE);
    assign round_done = done_q;
    assign win        = win_q;
    assign pair       = pair_q;
    assign score      = score_q;

endmodule

// File: tb/tb_slot_reel_controller.sv
// Randomised scoreboard bench for slot_reel_controller.
// Two instances share stimulus; the second has a 4-bit score.
module tb_slot_reel_controller;

    localparam int N    = 3;
    localparam int S    = 2;
    localparam int MAXS = 15;

    logic         clk_1Hz = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] stop = '0;

    logic [N*S-1:0] reels, reels4;
    logic [N-1:0]   spinning, spinning4;
    logic           busy, busy4, rd, rd4;
    logic           win, win4, pair, pair4;
    logic [7:0]     score;
    logic [3:0]     score4;

    slot_reel_controller dut (
        .clk_1Hz    (clk_1Hz),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .reels      (reels),
        .spinning   (spinning),
        .busy       (busy),
        .round_done (rd),
        .win        (win),
        .pair       (pair),
        .score      (score)
    );

    slot_reel_controller #(.SCORE_W(4)) dut4 (
        .clk_1Hz    (clk_1Hz),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .reels      (reels4),
        .spinning   (spinning4),
        .busy       (busy4),
        .round_done (rd4),
        .win        (win4),
        .pair       (pair4),
        .score      (score4)
    );

    always #5 clk_1Hz = ~clk_1Hz;

    typedef struct {
        logic [N*S-1:0] reels;
        bit             win;
        bit             pair;
        int             score;
        int             score4;
    } exp_t;

    exp_t           q[$];
    exp_t           mon_e;
    int             checks = 0;
    int             errors = 0;
    int             rd_count = 0;
    logic [15:0]    mlfsr;
    logic [S-1:0]   mreel[N];
    int             mscore, mscore4;
    bit             mwin, mpair;
    int             kk[N];

    function automatic logic [15:0] nxt(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    function automatic logic [N*S-1:0] packr();
        logic [N*S-1:0] r;
        for (int i = 0; i < N; i++) r[i*S +: S] = mreel[i];
        return r;
    endfunction

    task automatic chk(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h",
                     nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk_1Hz);
        mlfsr = nxt(mlfsr);
        @(negedge clk_1Hz);
    endtask

    always @(negedge clk_1Hz) begin
        if (!rst && (rd || rd4)) begin
            rd_count++;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL round_done unexpected pulse");
            end else begin
                mon_e = q.pop_front();
                chk("rd", rd, 1);
                chk("rd4", rd4, 1);
                chk("reels", reels, mon_e.reels);
                chk("win", win, mon_e.win);
                chk("pair", pair, mon_e.pair);
                chk("score", score, mon_e.score);
                chk("score4", score4, mon_e.score4);
                chk("win4", win4, mon_e.win);
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        stop = '0;
        #1;
        chk("rst_reels", {reels4, reels}, 0);
        chk("rst_spin", {spinning4, spinning}, 0);
        chk("rst_busy", {busy4, busy}, 0);
        chk("rst_rd", {rd4, rd}, 0);
        chk("rst_win", {win4, win, pair4, pair}, 0);
        chk("rst_score", {score4, score}, 0);
        chk("rst_lfsr", dut.u_lfsr.lfsr, 16'hACE1);
        q.delete();
        mlfsr = 16'hACE1;
        for (int i = 0; i < N; i++) mreel[i] = '0;
        mscore = 0;
        mscore4 = 0;
        mwin = 0;
        mpair = 0;
        @(negedge clk_1Hz);
        rst = 1'b0;
    endtask

    // Plan-level model: reel i stops at SPIN edge eff[i] and
    // keeps the symbol sampled on its last loading edge.
    task automatic run_round();
        int   eff[N];
        int   len;
        bit   all, any;
        int   pts;
        exp_t e;
        len = 0;
        for (int i = 0; i < N; i++) begin
            eff[i] = (kk[i] > MAXS) ? MAXS : kk[i];
            if (eff[i] > len) len = eff[i];
        end
        start = 1'b1;
        stop = N'($urandom);
        tick();
        chk("spin_start", spinning, {N{1'b1}});
        chk("busy_start", busy, 1);
        for (int ed = 1; ed <= len; ed++) begin
            logic [N-1:0] sp;
            start = 1'($urandom);
            for (int i = 0; i < N; i++) begin
                stop[i] = (ed == kk[i]) ||
                          (ed > kk[i] && 1'($urandom));
                if (ed < eff[i]) mreel[i] = mlfsr[i*S +: S];
                sp[i] = (ed < eff[i]);
            end
            tick();
            chk("spinning", spinning, sp);
            chk("reels_spin", reels, packr());
            chk("busy_spin", busy, 1);
        end
        all = 1;
        any = 0;
        for (int i = 0; i < N; i++)
            for (int j = i + 1; j < N; j++)
                if (mreel[i] == mreel[j]) any = 1;
                else all = 0;
        pts = all ? 10 : (any ? 1 : 0);
        mwin = all;
        mpair = any && !all;
        mscore = (mscore + pts > 255) ? 255 : mscore + pts;
        mscore4 = (mscore4 + pts > 15) ? 15 : mscore4 + pts;
        e.reels = packr();
        e.win = mwin;
        e.pair = mpair;
        e.score = mscore;
        e.score4 = mscore4;
        q.push_back(e);
        start = 1'($urandom);
        stop = N'($urandom);
        tick();
        chk("busy_after", busy, 0);
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            start = 1'b0;
            stop = N'($urandom);
            tick();
            chk("idle_busy", busy, 0);
            chk("idle_rd", rd, 0);
            chk("idle_spin", spinning, 0);
            chk("idle_reels", reels, packr());
            chk("idle_wp", {win, pair}, {mwin, mpair});
            chk("idle_score", {score4, score},
                {mscore4[3:0], mscore[7:0]});
        end
    endtask

    task automatic abort_round(input int n);
        start = 1'b1;
        tick();
        start = 1'b0;
        stop = '0;
        for (int c = 0; c < n; c++) tick();
        chk("abort_busy", busy, 1);
        do_reset();
    endtask

    initial begin
        int rc;
        @(negedge clk_1Hz);
        do_reset();
        abort_round(3);

        kk = '{2, 2, 2};
        run_round();
        chk("pair_reels", reels, 6'b11_00_00);
        chk("pair_flag", pair, 1);
        chk("pair_win", win, 0);
        chk("pair_score", score, 1);
        idle(3);

        do_reset();
        kk = '{1, 4, 4};
        run_round();
        chk("stag_reel0", reels[1:0], 0);
        idle(1);

        rc = rd_count;
        kk = '{99, 99, 99};
        run_round();
        idle(2);
        chk("timeout_pulses", rd_count - rc, 1);

        for (int r = 0; r < 250; r++) begin
            if ($urandom_range(0, 39) == 0)
                abort_round($urandom_range(1, 6));
            for (int i = 0; i < N; i++)
                kk[i] = $urandom_range(1, MAXS + 3);
            run_round();
            idle($urandom_range(0, 2));
        end
        idle(2);
        chk("queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule

// File: doc/slot_reel_controller.md
Name: slot_reel_controller

Overview:
- Parametrised N-reel slot-machine controller; the successor to the fixed 3-channel random-display block.
- Free-running internal LFSR supplies symbols; reels spin on start and stop individually by player buttons, or all together on a spin timeout.
- A round FSM evaluates the final symbols for an all-equal (win) or any-two-equal (pair) result and accumulates a saturating score.
- Sits between debounced button inputs and the display/scoring logic.

Parameters:
- NUM_REELS, 3, number of reels (2..8).
- SYM_W, 2, bits per reel symbol; NUM_REELS*SYM_W <= LFSR_W.
- LFSR_W, 16, LFSR width.
- LFSR_SEED, 16'hACE1, reset value of the LFSR; a value of 0 is replaced by 1.
- LFSR_TAPS, 16'hB400, Galois feedback mask.
- MAX_SPIN, 15, maximum SPIN cycles before forced stop.
- SCORE_W, 8, score width.
- WIN_PTS, 10, points for all reels equal.
- PAIR_PTS, 1, points for a pair (not awarded on a win).

Ports:
- clk_1Hz  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin round; sampled in IDLE only.
- stop  input  NUM_REELS  per-reel stop request; bit i maps to reel i.
- reels  output  NUM_REELS*SYM_W  packed symbols; reel i at [i*SYM_W +: SYM_W].
- spinning  output  NUM_REELS  reel i still updating.
- busy  output  1  state != IDLE.
- round_done  output  1  one-cycle pulse after evaluation.
- win  output  1  last round all equal; held until the next round_done.
- pair  output  1  last round has at least two equal reels but is not a win; held until the next round_done.
- score  output  SCORE_W  accumulated points; saturates at all-ones.

Behaviour:
- Reset (async): lfsr=LFSR_SEED (or 1 if the seed is 0), state=IDLE, reels=0, spinning=0, spin_cnt=0, round_done=0, win=0, pair=0, score=0.
- LFSR: advances on every clk_1Hz edge in every state.
  - If lfsr[0]=1: lfsr <= (lfsr>>1)^LFSR_TAPS.
  - Otherwise: lfsr <= lfsr>>1.
- Symbol source: reel loads sample the pre-edge lfsr value.
- IDLE:
  - start=1 -> SPIN, spinning=all ones, spin_cnt=0.
  - Reels are not updated on this edge.
  - stop is ignored in IDLE.
- SPIN, each edge:
  - spin_cnt += 1.
  - For each i with spinning[i]=1: if stop[i]=1, clear spinning[i] and hold reel i; otherwise reel i <= lfsr[i*SYM_W +: SYM_W].
  - Reels with spinning[i]=0 hold their value; stop on an already-stopped reel has no effect.
  - start is ignored.
- Timeout: if spin_cnt==MAX_SPIN-1 on a SPIN edge, every reel still spinning is stopped and held on that edge, regardless of stop.
- SPIN -> EVAL on the edge where the next value of spinning is all zero.
  - This covers simultaneous stops of several or all reels.
- EVAL, one edge:
  - win <= all reels equal.
  - pair <= !all-equal && some pair equal.
  - score <= sat(score + (win ? WIN_PTS : pair ? PAIR_PTS : 0)), saturating at 2^SCORE_W-1.
  - round_done <= 1; state -> IDLE.
- round_done is low on every other edge.
- All outputs are registered; evaluated results are visible one cycle after the EVAL edge.
- Reset mid-round aborts immediately to the reset values, including score.

Decomposition:
- Shared package slot_pkg holds:
  - state enum typedef {IDLE, SPIN, EVAL};
  - default constants for seed, taps, and point values;
  - a saturating-add function.
- One natural sub-module, lfsr_galois (params WIDTH, SEED, TAPS; ports clk, rst, lfsr).
- Match detection is combinational inside the top module as a pairwise compare loop.

Test Plan:
- Reset: assert rst mid-SPIN -> all outputs 0 immediately; lfsr=16'hACE1.
- Pair round (defaults):
  - Stimulus: release reset; start=1 at edge 1; edge 2 reels load from 0xE270; stop=3'b111 at edge 3.
  - Required: reels={3,0,0} (reel2..reel0) after edge 3; busy=1 through EVAL; after edge 4 round_done=1 for one cycle, pair=1, win=0, score=1.
- Staggered stop:
  - Stimulus: stop reel0 at edge 2 only, others at edge 5.
  - Required: reel0 frozen at 0 from 0xE270; reels 1 and 2 keep updating from the lfsr sequence 0x7138, 0x389C, and so on until stopped; spinning transitions 3'b110 -> 3'b000.
- Timeout: start with stop held 0 -> after MAX_SPIN=15 SPIN edges spinning=0, EVAL follows, round_done pulses exactly once.
- Ignored inputs: start during SPIN and stop during IDLE -> no state, reel, or score change.
- Win and saturation: force LFSR_SEED/params so that all reels match (or use the reference-model search) -> win=1, score += 10; preload score near max (SCORE_W=4) -> score saturates at 15, no wrap.
